// File: rtl/motor_bridge_driver.sv
// motor_bridge_driver
//   Drives two H-bridge motor channels from 2-bit direction codes and enables.
//   Each channel has its own OFF/FWD/REV/DEAD state machine. Leaving a driving
//   state always forces DEAD_CYCLES cycles with both legs low. Both channels
//   share one free-running PWM counter that chops the active leg.
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   en1/y1, en2/y2      : per-channel enable and direction code (00 stop, 01 fwd, 10 rev, 11 illegal)
//   duty                : shared PWM on-time (0 = never on, all-ones = always on)
//   m1_a/m1_b, m2_a/m2_b: registered bridge inputs (a = forward leg, b = reverse leg)
//   busy1, busy2        : high while the channel sits in DEAD
//   fault               : sticky flag, set by an enabled 11 code, cleared only by reset

// One bridge channel: effective-command decode, dead-time FSM, registered leg outputs.
module motor_bridge_chan #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] y_i,
    input  logic       pwm_on_i,   // PWM state for the cycle following this edge
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       illegal_o
);
    typedef enum logic [1:0] {S_OFF, S_FWD, S_REV, S_DEAD} state_t;

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [1:0] cmd;
    logic       a_q, b_q, busy_q;

    // Disabled or illegal codes both collapse to stop.
    assign illegal_o = en_i && (y_i == 2'b11);
    assign cmd       = (en_i && !illegal_o) ? y_i : 2'b00;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_OFF: begin
                if (cmd == 2'b01)      state_d = S_FWD;
                else if (cmd == 2'b10) state_d = S_REV;
            end
            S_FWD: begin
                if (cmd != 2'b01) begin
                    state_d = S_DEAD;
                    dcnt_d  = DEAD_LOAD;
                end
            end
            S_REV: begin
                if (cmd != 2'b10) begin
                    state_d = S_DEAD;
                    dcnt_d  = DEAD_LOAD;
                end
            end
            default: begin
                // Exit target is whatever cmd says on the final edge; earlier
                // command changes are ignored so the dead-time is never cut short.
                if (dcnt_q == 8'd0) begin
                    if (cmd == 2'b01)      state_d = S_FWD;
                    else if (cmd == 2'b10) state_d = S_REV;
                    else                   state_d = S_OFF;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            dcnt_q  <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            // Decoding from a single next-state makes a/b mutually exclusive.
            a_q     <= (state_d == S_FWD) && pwm_on_i;
            b_q     <= (state_d == S_REV) && pwm_on_i;
            busy_q  <= (state_d == S_DEAD);
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign busy_o = busy_q;
endmodule

module motor_bridge_driver #(
    parameter int DEAD_CYCLES = 4,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en1,
    input  logic [1:0]          y1,
    input  logic                en2,
    input  logic [1:0]          y2,
    input  logic [PWM_BITS-1:0] duty,
    output logic                m1_a,
    output logic                m1_b,
    output logic                m2_a,
    output logic                m2_b,
    output logic                busy1,
    output logic                busy2,
    output logic                fault
);
    localparam int NUM_CH = 2;

    logic [PWM_BITS-1:0]         pcnt_q, pcnt_d;
    logic                        pwm_on_d;
    logic                        fault_q;
    logic [NUM_CH-1:0]           en_v, a_v, b_v, busy_v, ill_v;
    logic [NUM_CH-1:0][1:0]      y_v;

    // Outputs are registered from next-pcnt so they line up with the counter
    // value present during the following cycle.
    assign pcnt_d   = pcnt_q + 1'b1;
    assign pwm_on_d = (pcnt_d < duty) || (&duty);

    assign en_v = {en2, en1};
    assign y_v  = {y2, y1};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        motor_bridge_chan #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch (
            .clk_i    (clk),
            .rst_i    (reset),
            .en_i     (en_v[c]),
            .y_i      (y_v[c]),
            .pwm_on_i (pwm_on_d),
            .a_o      (a_v[c]),
            .b_o      (b_v[c]),
            .busy_o   (busy_v[c]),
            .illegal_o(ill_v[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            fault_q <= fault_q || (|ill_v);
        end
    end

    assign m1_a  = a_v[0];
    assign m1_b  = b_v[0];
    assign m2_a  = a_v[1];
    assign m2_b  = b_v[1];
    assign busy1 = busy_v[0];
    assign busy2 = busy_v[1];
    assign fault = fault_q;
endmodule

// File: tb/tb_motor_bridge_driver.sv
module tb_motor_bridge_driver;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0;
    logic [1:0] y1 = 2'b00, y2 = 2'b00;
    logic [7:0] duty = 8'd0;
    logic       m1_a, m1_b, m2_a, m2_b, busy1, busy2, fault;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: per channel, a driven direction (0 none, 1 fwd, 2 rev)
    // and the number of dead cycles still owed; edge count gives the PWM phase.
    int  dir [2];
    int  dead [2];
    int  edges;
    bit  m_fault;
    logic [6:0] exp_v;   // {m1_a,m1_b,m2_a,m2_b,busy1,busy2,fault}

    motor_bridge_driver #(.DEAD_CYCLES(DC), .PWM_BITS(8)) dut (
        .clk(clk), .reset(reset), .en1(en1), .y1(y1), .en2(en2), .y2(y2),
        .duty(duty), .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
        .busy1(busy1), .busy2(busy2), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        dir[0] = 0; dir[1] = 0; dead[0] = 0; dead[1] = 0;
        edges = 0; m_fault = 0; exp_v = '0;
    endtask

    task automatic model_ch(input int c, input bit en, input bit [1:0] y);
        int cmd;
        cmd = (!en || y == 2'b11) ? 0 : int'(y);
        if (en && y == 2'b11) m_fault = 1;
        if (dead[c] > 0) begin
            dead[c]--;
            if (dead[c] == 0) dir[c] = cmd;
        end else if (dir[c] == 0) begin
            dir[c] = cmd;
        end else if (cmd != dir[c]) begin
            dir[c] = 0;
            dead[c] = DC;
        end
    endtask

    task automatic model_step();
        bit pwm;
        model_ch(0, en1, y1);
        model_ch(1, en2, y2);
        edges = (edges + 1) % 256;
        pwm = (edges < int'(duty)) || (duty == 8'hFF);
        exp_v = {dir[0] == 1 && pwm, dir[0] == 2 && pwm,
                 dir[1] == 1 && pwm, dir[1] == 2 && pwm,
                 dead[0] > 0, dead[1] > 0, m_fault};
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            n_chk++;
            if ({m1_a, m1_b, m2_a, m2_b, busy1, busy2, fault} !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b", $time,
                         {m1_a, m1_b, m2_a, m2_b, busy1, busy2, fault}, exp_v);
            end
            n_chk++;
            if ((m1_a & m1_b) | (m2_a & m2_b)) begin
                n_fail++;
                $display("FAIL shoot_through t=%0t m1=%b%b m2=%b%b", $time, m1_a, m1_b, m2_a, m2_b);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        int cnt;
        #3 reset = 1'b1;
        #1 chk("reset_outs", {25'd0, m1_a, m1_b, m2_a, m2_b, busy1, busy2, fault}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset mid-run, asynchronous clear and fresh start from OFF.
        duty = 8'hFF; en1 = 1; y1 = 2'b01;
        repeat (5) @(negedge clk);
        chk("fwd_before_rst", m1_a, 1);
        #1 reset = 1'b1;
        #1 chk("async_rst_m1a", {m1_a, m1_b, busy1, fault}, 0);
        #1 reset = 1'b0;
        after_edge();
        chk("first_edge_after_rst", m1_a, 1);

        // Reversal FWD -> REV: four dead cycles then b drives.
        @(negedge clk); y1 = 2'b10;
        for (int k = 0; k < DC; k++) begin
            after_edge();
            chk("rev_dead_legs", {m1_a, m1_b}, 0);
            chk("rev_dead_busy", busy1, 1);
        end
        after_edge();
        chk("rev_drive_b", {m1_a, m1_b, busy1}, 3'b010);

        // Abort during DEAD: going back to REV still costs a full dead period.
        @(negedge clk); y1 = 2'b00;
        after_edge();
        chk("abort_dead0", {m1_b, busy1}, 2'b01);
        y1 = 2'b10;
        for (int k = 1; k < DC; k++) begin
            after_edge();
            chk("abort_dead", {m1_a, m1_b, busy1}, 3'b001);
        end
        after_edge();
        chk("abort_exit_rev", {m1_b, busy1}, 2'b10);

        // FWD, then glitch 00 for one cycle then 01 again.
        @(negedge clk); y1 = 2'b01;
        repeat (DC + 3) @(negedge clk);
        y1 = 2'b00;
        after_edge();
        y1 = 2'b01;
        repeat (DC - 1) after_edge();
        chk("glitch_still_dead", {m1_a, busy1}, 2'b01);
        after_edge();
        chk("glitch_exit_fwd", {m1_a, busy1}, 2'b10);

        // PWM duty on channel 2 while channel 1 keeps reversing.
        do_reset();
        en2 = 1; y2 = 2'b01; duty = 8'd64; en1 = 1; y1 = 2'b01;
        repeat (4) @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k % 20 == 0) y1 = (y1 == 2'b01) ? 2'b10 : 2'b01;
            cnt += m2_a;
            if (busy2) cnt += 1000;
        end
        chk("duty64_on_count", cnt, 64);
        duty = 8'd0; cnt = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 256; k++) begin @(negedge clk); cnt += m2_a; end
        chk("duty0_on_count", cnt, 0);
        duty = 8'hFF; cnt = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 256; k++) begin @(negedge clk); cnt += m2_a; end
        chk("duty255_on_count", cnt, 256);

        // Enable gating and sticky fault.
        do_reset();
        en1 = 0; y1 = 2'b01; en2 = 1; y2 = 2'b11;
        repeat (3) @(negedge clk);
        chk("en1_off", {m1_a, m1_b, busy1}, 0);
        chk("ill_as_stop", {m2_a, m2_b, busy2}, 0);
        chk("fault_set", fault, 1);
        y2 = 2'b00; en1 = 1; y1 = 2'b11; en1 = 0;
        repeat (3) @(negedge clk);
        chk("fault_sticky", fault, 1);
        do_reset();
        chk("fault_cleared", fault, 0);

        // Randomized phase; the model comparison runs every cycle.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                en1 = ($urandom_range(0, 7) != 0);
                y1  = ($urandom_range(0, 30) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 5) == 0) begin
                en2 = ($urandom_range(0, 7) != 0);
                y2  = ($urandom_range(0, 30) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 50) == 0) duty = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 400) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
